// File: rtl/dpram_sched_pkg.sv
// dpram_sched_pkg: shared types and constants for the dual-port RAM port scheduler
package dpram_sched_pkg;
  localparam int MAX_ID_W = 3;
  localparam logic PORT1 = 1'b0;
  localparam logic PORT2 = 1'b1;
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                port;
  } rsp_pipe_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/dpram_rr_pick.sv
// dpram_rr_pick: find-first-set over req & ~excl, scanning from ptr with wrap at N-1
module dpram_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  excl,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);
  // Rotating scan; explicit wrap so non-power-of-two N works
  always_comb begin
    int j;
    found = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      j = j >= N ? j - N : j;
      if (!found && req[j] && !excl[j]) begin
        found = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/dpram_port_scheduler.sv
// dpram_port_scheduler: round-robin sharing of a dual-port RAM among NREQ requesters (optional stats: DPRAM_SCHED_STATS_EN)
module dpram_port_scheduler
  import dpram_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = 8,
  parameter int AW     = 6,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [NREQ*DW-1:0] rsp_data,
  output logic [DW-1:0]      ram_data_p1,
  output logic [DW-1:0]      ram_data_p2,
  output logic [AW-1:0]      ram_addr_p1,
  output logic [AW-1:0]      ram_addr_p2,
  output logic               ram_wr_p1,
  output logic               ram_wr_p2,
`ifdef DPRAM_SCHED_STATS_EN
  output logic [15:0]        stat_grants,
  output logic [15:0]        stat_conflicts,
`endif
  input  logic [DW-1:0]      ram_out_p1,
  input  logic [DW-1:0]      ram_out_p2
);
  localparam int IW = id_w(NREQ);
  logic [NREQ-1:0]    vld, a_oh, b_oh, haz, rsp_v_nxt;
  logic [IW-1:0]      rr_ptr, a_idx, b_idx, b_ptr, last_idx, nxt_ptr;
  logic               a_ok, b_ok, wr_a, wr_b, conflict;
  logic [AW-1:0]      addr_a, addr_b;
  logic [NREQ*DW-1:0] rsp_d_nxt;
  rsp_pipe_t [1:0]    push;
  rsp_pipe_t [1:0]    pipe [RD_LAT];
  assign vld = rst ? '0 : req_valid;
  assign addr_a = req_addr[a_idx*AW +: AW];
  assign addr_b = req_addr[b_idx*AW +: AW];
  assign wr_a = req_wr[a_idx];
  assign wr_b = req_wr[b_idx];
  assign b_ptr = a_idx == IW'(NREQ-1) ? '0 : a_idx + 1'b1;
  assign last_idx = b_ok ? b_idx : a_idx;
  assign nxt_ptr = last_idx == IW'(NREQ-1) ? '0 : last_idx + 1'b1;
  dpram_rr_pick #(.N(NREQ), .IW(IW)) u_pick_a (
    .req(vld), .excl('0), .ptr(rr_ptr), .found(a_ok), .idx(a_idx)
  );
  dpram_rr_pick #(.N(NREQ), .IW(IW)) u_pick_b (
    .req(vld), .excl(a_oh | haz), .ptr(b_ptr), .found(b_ok), .idx(b_idx)
  );
  // Grant one-hots and same-address-with-write hazards against pick A
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      a_oh[i] = a_ok && a_idx == IW'(i);
      b_oh[i] = b_ok && b_idx == IW'(i);
      haz[i] = req_addr[i*AW +: AW] == addr_a && (req_wr[i] || wr_a);
    end
  end
  assign conflict = |(vld & haz & ~a_oh);
  assign req_ready = a_oh | b_oh;
  assign ram_addr_p1 = a_ok ? addr_a : '0;
  assign ram_data_p1 = a_ok ? req_data[a_idx*DW +: DW] : '0;
  assign ram_wr_p1 = a_ok && wr_a;
  assign ram_addr_p2 = b_ok ? addr_b : '0;
  assign ram_data_p2 = b_ok ? req_data[b_idx*DW +: DW] : '0;
  assign ram_wr_p2 = b_ok && wr_b;
  assign push[0] = '{valid: a_ok && !wr_a, id: MAX_ID_W'(a_idx), port: PORT1};
  assign push[1] = '{valid: b_ok && !wr_b, id: MAX_ID_W'(b_idx), port: PORT2};
  // Route RAM read data of exiting pipe entries to their requesters
  always_comb begin
    rsp_v_nxt = '0;
    rsp_d_nxt = rsp_data;
    for (int l = 0; l < 2; l++)
      for (int i = 0; i < NREQ; i++)
        if (pipe[RD_LAT-1][l].valid && pipe[RD_LAT-1][l].id == MAX_ID_W'(i)) begin
          rsp_v_nxt[i] = 1'b1;
          rsp_d_nxt[i*DW +: DW] = pipe[RD_LAT-1][l].port == PORT2 ? ram_out_p2 : ram_out_p1;
        end
  end
  // Round-robin pointer, read-tracking pipe and registered responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      pipe <= '{default: '0};
      rsp_valid <= '0;
      rsp_data <= '0;
    end else begin
      if (a_ok) rr_ptr <= nxt_ptr;
      pipe[0] <= push;
      for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
      rsp_valid <= rsp_v_nxt;
      rsp_data <= rsp_d_nxt;
    end
  end
`ifdef DPRAM_SCHED_STATS_EN
  logic [16:0] grant_sum;
  assign grant_sum = {1'b0, stat_grants} + 17'(a_ok) + 17'(b_ok);
  // Saturating grant and hazard-conflict counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_grants <= grant_sum[16] ? 16'hFFFF : grant_sum[15:0];
      if (conflict && stat_conflicts != 16'hFFFF) stat_conflicts <= stat_conflicts + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dpram_port_scheduler.sv
// tb_dpram_port_scheduler: directed self-checking bench with a behavioural RD_LAT=1 dual-port RAM
module tb_dpram_port_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_wr = '0;
  logic [23:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [7:0]  ram_data_p1, ram_data_p2, ram_out_p1, ram_out_p2;
  logic [5:0]  ram_addr_p1, ram_addr_p2;
  logic        ram_wr_p1, ram_wr_p2;
  logic [7:0]  mem [64];
  int          n_chk = 0;
  int          n_fail = 0;
`ifdef DPRAM_SCHED_STATS_EN
  logic [15:0] stat_grants, stat_conflicts;
`endif
  dpram_port_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_data_p1(ram_data_p1), .ram_data_p2(ram_data_p2), .ram_addr_p1(ram_addr_p1),
    .ram_addr_p2(ram_addr_p2), .ram_wr_p1(ram_wr_p1), .ram_wr_p2(ram_wr_p2),
`ifdef DPRAM_SCHED_STATS_EN
    .stat_grants(stat_grants), .stat_conflicts(stat_conflicts),
`endif
    .ram_out_p1(ram_out_p1), .ram_out_p2(ram_out_p2)
  );
  always #5 clk = ~clk;
  initial for (int a = 0; a < 64; a++) mem[a] = 8'(a + 8'h80);
  always @(posedge clk) begin
    if (ram_wr_p1) mem[ram_addr_p1] <= ram_data_p1;
    if (ram_wr_p2) mem[ram_addr_p2] <= ram_data_p2;
    ram_out_p1 <= mem[ram_addr_p1];
    ram_out_p2 <= mem[ram_addr_p2];
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic put(input int i, input logic wr, input logic [5:0] a, input logic [7:0] d);
    req_valid[i] = 1'b1;
    req_wr[i] = wr;
    req_addr[i*6 +: 6] = a;
    req_data[i*8 +: 8] = d;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick; tick;
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_wr", {ram_wr_p1, ram_wr_p2}, 2'b00);
    chk("rst_ptr", dut.rr_ptr, 2'd0);
    rst = 1'b0;
    tick;
    put(0, 1'b1, 6'h01, 8'h45);
    put(1, 1'b1, 6'h02, 8'h32);
    #1;
    chk("wr2_ready", req_ready, 4'b0011);
    chk("wr2_p1", {ram_wr_p1, ram_addr_p1, ram_data_p1}, {1'b1, 6'h01, 8'h45});
    chk("wr2_p2", {ram_wr_p2, ram_addr_p2, ram_data_p2}, {1'b1, 6'h02, 8'h32});
    tick;
    chk("wr2_ptr", dut.rr_ptr, 2'd2);
    req_valid = '0;
    put(2, 1'b0, 6'h01, 8'h00);
    put(3, 1'b0, 6'h02, 8'h00);
    #1;
    chk("rd2_ready", req_ready, 4'b1100);
    chk("rd2_ports", {ram_wr_p1, ram_addr_p1, ram_wr_p2, ram_addr_p2}, {1'b0, 6'h01, 1'b0, 6'h02});
    tick;
    req_valid = '0;
    chk("rd2_early", rsp_valid, 4'b0000);
    tick;
    chk("rd2_rsp_valid", rsp_valid, 4'b1100);
    chk("rd2_rsp_data", rsp_data, 32'h3245_0000);
    tick;
    chk("rd2_pulse", rsp_valid, 4'b0000);
    chk("rd2_hold", rsp_data, 32'h3245_0000);
    put(0, 1'b1, 6'h03, 8'h24);
    put(1, 1'b0, 6'h03, 8'h00);
    #1;
    chk("haz_ready", req_ready, 4'b0001);
    chk("haz_p2_idle", {ram_wr_p2, ram_addr_p2, ram_data_p2}, 15'h0);
    tick;
    req_valid[0] = 1'b0;
    #1;
    chk("haz_retry_ready", req_ready, 4'b0010);
    chk("haz_retry_p1", {ram_wr_p1, ram_addr_p1}, {1'b0, 6'h03});
    tick;
    req_valid = '0;
    tick;
    chk("haz_rsp_valid", rsp_valid, 4'b0010);
    chk("haz_rsp_data", rsp_data, 32'h3245_2400);
`ifdef DPRAM_SCHED_STATS_EN
    chk("stat_grants_a", stat_grants, 16'd6);
    chk("stat_conflicts_a", stat_conflicts, 16'd1);
`endif
    put(3, 1'b0, 6'h01, 8'h00);
    #1;
    chk("mid_ready", req_ready, 4'b1000);
    tick;
    req_valid = '0;
    put(0, 1'b1, 6'h07, 8'h99);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp", rsp_valid, 4'b0000);
    chk("mid_rst_wr", {ram_wr_p1, ram_wr_p2}, 2'b00);
    chk("mid_rst_ready", req_ready, 4'b0000);
`ifdef DPRAM_SCHED_STATS_EN
    chk("mid_rst_stats", {stat_grants, stat_conflicts}, 32'h0);
`endif
    tick; tick;
    chk("mid_rst_ptr", dut.rr_ptr, 2'd0);
    req_valid = '0;
    rst = 1'b0;
    tick;
    chk("mid_dropped", rsp_valid, 4'b0000);
    for (int i = 0; i < 4; i++) put(i, 1'b0, 6'(6'h10 + i), 8'h00);
    #1;
    chk("rr_c1", req_ready, 4'b0011);
    tick;
    chk("rr_c2", req_ready, 4'b1100);
    chk("rr_c2_rsp", rsp_valid, 4'b0000);
    tick;
    chk("rr_c3", req_ready, 4'b0011);
    chk("rr_c3_rsp", rsp_valid, 4'b0011);
    chk("rr_c3_data", rsp_data[15:0], 16'h9190);
    tick;
    chk("rr_c4", req_ready, 4'b1100);
    chk("rr_c4_rsp", rsp_valid, 4'b1100);
    chk("rr_c4_data", rsp_data[31:16], 16'h9392);
    tick;
    req_valid = '0;
    chk("rr_ptr_wrap", dut.rr_ptr, 2'd0);
    chk("rr_c5_rsp", rsp_valid, 4'b0011);
    tick;
    chk("rr_c6_rsp", rsp_valid, 4'b1100);
    put(0, 1'b0, 6'h05, 8'h00);
    put(1, 1'b0, 6'h05, 8'h00);
    #1;
    chk("same_rd_ready", req_ready, 4'b0011);
    chk("same_rd_ports", {ram_wr_p1, ram_addr_p1, ram_wr_p2, ram_addr_p2}, {1'b0, 6'h05, 1'b0, 6'h05});
    tick;
    req_valid = '0;
    tick;
    chk("same_rd_rsp", rsp_valid, 4'b0011);
    chk("same_rd_data", rsp_data[15:0], 16'h8585);
`ifdef DPRAM_SCHED_STATS_EN
    chk("stat_grants_b", stat_grants, 16'd10);
    chk("stat_conflicts_b", stat_conflicts, 16'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
